// File: rtl/uart_dbg_bridge_pkg.sv
// Shared constants for the UART debug bridge.
// States, command opcodes, reply bytes and the RX empty marker.
package uart_dbg_bridge_pkg;

   typedef logic [2:0] state_t;

   localparam state_t IDLE = 3'd0;
   localparam state_t ADDR = 3'd1;
   localparam state_t DATA = 3'd2;
   localparam state_t BUS  = 3'd3;
   localparam state_t RESP = 3'd4;

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] RSP_OK    = 8'h4B;
   localparam logic [7:0] RSP_ERR   = 8'h3F;

   localparam logic [31:0] RX_EMPTY = 32'hFFFF_FFFF;

endpackage

// File: rtl/uart_dbg_bridge_if.sv
// UART byte register port plus native memory bus.
// master = bridge side, slave = UART/arbiter side.
interface uart_dbg_bridge_if;

   logic        reg_dat_we;
   logic        reg_dat_re;
   logic [31:0] reg_dat_di;
   logic [31:0] reg_dat_do;
   logic        reg_dat_ack;

   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;

   modport master (
      output reg_dat_we, reg_dat_re, reg_dat_di,
      input  reg_dat_do, reg_dat_ack,
      output mem_valid, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  reg_dat_we, reg_dat_re, reg_dat_di,
      output reg_dat_do, reg_dat_ack,
      input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata
   );

endinterface

// File: rtl/uart_dbg_bridge_tx.sv
// Single-byte sender: holds we/di until the UART acks.
// done pulses in the ack cycle; we drops on the next edge.
module uart_dbg_bridge_tx (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic [7:0]  data,
   input  logic        ack,
   output logic        we,
   output logic [31:0] di,
   output logic        done
);

   assign done = we & ack;

   // Latch a byte on start and hold it until acknowledged
   always_ff @(posedge clk) begin
      if (!resetn) begin
         we <= 1'b0;
         di <= 32'h0;
      end else if (we) begin
         if (ack) we <= 1'b0;
      end else if (start) begin
         we <= 1'b1;
         di <= {24'h0, data};
      end
   end

endmodule

// File: rtl/uart_dbg_bridge.sv
// UART byte-command to 32-bit bus debug master.
// Define UART_DBG_BRIDGE_TIMEOUT_EN for the inter-byte timeout.
module uart_dbg_bridge
   import uart_dbg_bridge_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic              clk,
   input  logic              resetn,
   uart_dbg_bridge_if.master bus,
   output logic              busy
);

   state_t      state;
   logic [1:0]  idx;
   logic        is_rd;
   logic        rsp_err;
   logic        re_q;
   logic        mem_valid;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        collect;
   logic        take;
   logic        tmo;
   logic [7:0]  rx_byte;
   logic [7:0]  tx_byte;
   logic        tx_start;
   logic        tx_we;
   logic        tx_done;
   logic [31:0] tx_di;
   logic        op_ok;

   assign collect = (state == IDLE) || (state == ADDR) || (state == DATA);
   assign take    = resetn && collect && !bus.reg_dat_do[31]
                    && !re_q && !tx_we;
   assign rx_byte = bus.reg_dat_do[7:0];
   assign op_ok   = (rx_byte == CMD_READ) || (rx_byte == CMD_WRITE);
   assign busy    = state != IDLE;

   assign bus.reg_dat_re = take;
   assign bus.reg_dat_we = tx_we;
   assign bus.reg_dat_di = tx_di;
   assign bus.mem_valid  = mem_valid;
   assign bus.mem_addr   = addr & ~32'h3;
   assign bus.mem_wdata  = wdata;
   assign bus.mem_wstrb  = (mem_valid && !is_rd) ? 4'hF : 4'h0;

   assign tx_start = (state == RESP) && !tx_we;
   assign tx_byte  = rsp_err ? RSP_ERR :
                     is_rd   ? rdata[{idx, 3'b000} +: 8] : RSP_OK;

`ifdef UART_DBG_BRIDGE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tcnt;
   logic          at_lim;
   logic          rx_phase;

   assign rx_phase = (state == ADDR) || (state == DATA);
   assign at_lim   = tcnt == TW'(TIMEOUT_CYCLES);
   assign tmo      = rx_phase && at_lim && !take;

   // Inter-byte watchdog for partially received commands
   always_ff @(posedge clk) begin
      if (!resetn || take || !rx_phase) tcnt <= '0;
      else if (!at_lim) tcnt <= tcnt + TW'(1);
   end
`else
   assign tmo = 1'b0;
`endif

   uart_dbg_bridge_tx u_tx (
      .clk    (clk),
      .resetn (resetn),
      .start  (tx_start),
      .data   (tx_byte),
      .ack    (bus.reg_dat_ack),
      .we     (tx_we),
      .di     (tx_di),
      .done   (tx_done)
   );

   // Command parser, bus sequencer and reply stepping
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= IDLE;
         idx       <= 2'd0;
         is_rd     <= 1'b0;
         rsp_err   <= 1'b0;
         re_q      <= 1'b0;
         mem_valid <= 1'b0;
         addr      <= 32'h0;
         wdata     <= 32'h0;
         rdata     <= 32'h0;
      end else begin
         re_q <= take;
         case (state)
            IDLE: if (take) begin
               idx     <= 2'd0;
               is_rd   <= rx_byte == CMD_READ;
               rsp_err <= !op_ok;
               state   <= op_ok ? ADDR : RESP;
            end
            ADDR: if (tmo) state <= IDLE;
            else if (take) begin
               addr[{idx, 3'b000} +: 8] <= rx_byte;
               idx <= idx + 2'd1;
               if (idx == 2'd3) begin
                  state     <= is_rd ? BUS : DATA;
                  mem_valid <= is_rd;
               end
            end
            DATA: if (tmo) state <= IDLE;
            else if (take) begin
               wdata[{idx, 3'b000} +: 8] <= rx_byte;
               idx <= idx + 2'd1;
               if (idx == 2'd3) begin
                  state     <= BUS;
                  mem_valid <= 1'b1;
               end
            end
            BUS: if (bus.mem_ready) begin
               mem_valid <= 1'b0;
               rdata     <= bus.mem_rdata;
               idx       <= 2'd0;
               state     <= RESP;
            end
            RESP: if (tx_done) begin
               idx <= idx + 2'd1;
               if (rsp_err || !is_rd || idx == 2'd3) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
